// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared constants and types for the AXI4-Lite physical-memory responder
package axi_pkg;

  // FSM encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_WAIT = 3'd1;
  localparam logic [2:0] ST_RD_RESP = 3'd2;
  localparam logic [2:0] ST_WR_WAIT = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

  // AXI response codes; this block only ever returns OKAY
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Which request type won the most recent grant
  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_e;

endpackage

// File: rtl/axi_lite_pmem_slave_if.sv
// rtl/axi_lite_pmem_slave_if.sv - AXI4-Lite bus plus physical-memory access port
interface axi_lite_pmem_slave_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  // Read address / data channels
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  // Write address / data / response channels
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  // Memory access port: one-cycle read/write strobes toward simulated memory.
  // Read data is expected combinationally in the strobe cycle.
  logic                mem_rd_en;
  logic                mem_wr_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  mem_rdata,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output mem_rdata,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/axi_lite_pmem_slave_lat_counter.sv
// rtl/axi_lite_pmem_slave_lat_counter.sv - 4-bit loadable down-counter timing the memory wait
module lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_count;

  // Load has priority; decrement saturates at zero so the flag stays asserted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/axi_lite_pmem_slave.sv
// rtl/axi_lite_pmem_slave.sv - single-outstanding AXI4-Lite responder in front of simulated memory
module axi_lite_pmem_slave
  import axi_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input logic                  clk,
  input logic                  rst,
  axi_lite_pmem_slave_if.slave bus
);

  // Counter reload so the response rises exactly LATENCY edges after accept
  localparam logic [3:0]        LOAD_VAL   = 4'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-3){1'b1}}, 3'b000};

  logic [2:0]          r_state;
  grant_e              r_last_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_rdata;

  logic w_idle;
  logic w_wr_full;
  logic w_rd_wins;
  logic w_grant_rd;
  logic w_grant_wr;
  logic w_waiting;
  logic w_cnt_zero;

  // A write is only eligible when address and data arrive together.
  // On contention the type opposite to the previous grant wins.
  assign w_idle     = !rst && (r_state == ST_IDLE);
  assign w_wr_full  = bus.awvalid && bus.wvalid;
  assign w_rd_wins  = bus.arvalid && (!w_wr_full || (r_last_grant == GRANT_WR));
  assign w_grant_rd = w_idle && w_rd_wins;
  assign w_grant_wr = w_idle && w_wr_full && !w_rd_wins;
  assign w_waiting  = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT);

  lat_counter u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_grant_rd || w_grant_wr),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_waiting),
    .o_zero     (w_cnt_zero)
  );

  // Transaction FSM with request capture and read-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_WR;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_rd) begin
            r_state      <= ST_RD_WAIT;
            r_addr       <= bus.araddr;
            r_last_grant <= GRANT_RD;
          end else if (w_grant_wr) begin
            r_state      <= ST_WR_WAIT;
            r_addr       <= bus.awaddr;
            r_wdata      <= bus.wdata;
            r_wstrb      <= bus.wstrb;
            r_last_grant <= GRANT_WR;
          end
        end
        ST_RD_WAIT: begin
          if (w_cnt_zero) begin
            r_rdata <= bus.mem_rdata;
            r_state <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (bus.rready) r_state <= ST_IDLE;
        end
        ST_WR_WAIT: begin
          if (w_cnt_zero) r_state <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (bus.bready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs; everything reads as idle while reset is held
  assign bus.arready = w_grant_rd;
  assign bus.awready = w_grant_wr;
  assign bus.wready  = w_grant_wr;
  assign bus.rvalid  = !rst && (r_state == ST_RD_RESP);
  assign bus.bvalid  = !rst && (r_state == ST_WR_RESP);
  assign bus.rdata   = rst ? '0 : r_rdata;
  assign bus.rresp   = RESP_OKAY;
  assign bus.bresp   = RESP_OKAY;

  // Memory strobes fire for exactly one cycle, when the wait expires.
  // Gating with rst keeps a write caught by reset from ever committing.
  assign bus.mem_rd_en = !rst && (r_state == ST_RD_WAIT) && w_cnt_zero;
  assign bus.mem_wr_en = !rst && (r_state == ST_WR_WAIT) && w_cnt_zero;
  assign bus.mem_addr  = r_addr & ALIGN_MASK;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wstrb = r_wstrb;

endmodule

// File: tb/tb_axi_lite_pmem_slave.sv
// tb/tb_axi_lite_pmem_slave.sv - directed self-checking bench for axi_lite_pmem_slave
module tb_axi_lite_pmem_slave;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    int   wr_calls;
    int   wr4_calls;

    logic [63:0] mem [16];

    axi_lite_pmem_slave_if #(.ADDR_W(64), .DATA_W(64)) bus2 ();
    axi_lite_pmem_slave_if #(.ADDR_W(64), .DATA_W(64)) bus4 ();

    axi_lite_pmem_slave #(.LATENCY(2), .ADDR_W(64), .DATA_W(64)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    axi_lite_pmem_slave #(.LATENCY(4), .ADDR_W(64), .DATA_W(64)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus2.mem_rdata = mem[bus2.mem_addr[6:3]];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) mem[k] = 64'h0;
            mem[0] = 64'h00100073_00000413;
        end else if (bus2.mem_wr_en) begin
            for (int b = 0; b < 8; b++)
                if (bus2.mem_wstrb[b]) mem[bus2.mem_addr[6:3]][8*b +: 8] = bus2.mem_wdata[8*b +: 8];
            wr_calls = wr_calls + 1;
        end
    end

    assign bus4.mem_rdata = 64'h0;
    always @(posedge clk) begin
        if (bus4.mem_wr_en) wr4_calls = wr4_calls + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rd_req(input logic [63:0] a, output logic ok);
        bus2.araddr  = a;
        bus2.arvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (bus2.arready) ok = 1'b1;
            tick();
        end
        bus2.arvalid = 1'b0;
    endtask

    task automatic rd_resp(output logic [63:0] d, output logic [1:0] resp, output int lat);
        lat = 0;
        while (!bus2.rvalid && lat < 20) begin
            tick();
            lat++;
        end
        d    = bus2.rdata;
        resp = bus2.rresp;
        bus2.rready = 1'b1;
        tick();
        bus2.rready = 1'b0;
    endtask

    task automatic wr_req(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s, output logic ok);
        bus2.awaddr  = a;
        bus2.wdata   = d;
        bus2.wstrb   = s;
        bus2.awvalid = 1'b1;
        bus2.wvalid  = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (bus2.awready && bus2.wready) ok = 1'b1;
            tick();
        end
        bus2.awvalid = 1'b0;
        bus2.wvalid  = 1'b0;
    endtask

    task automatic wr_resp(output logic [1:0] resp, output int lat);
        lat = 0;
        while (!bus2.bvalid && lat < 20) begin
            tick();
            lat++;
        end
        resp = bus2.bresp;
        bus2.bready = 1'b1;
        tick();
        bus2.bready = 1'b0;
    endtask

    initial begin
        logic        ok;
        logic [63:0] d;
        logic [1:0]  resp;
        int          lat;
        int          got;
        int          wc;

        n_total = 0; n_pass = 0; wr_calls = 0; wr4_calls = 0;
        rst = 1'b1;
        bus2.araddr = '0; bus2.arvalid = 0; bus2.rready = 0;
        bus2.awaddr = '0; bus2.awvalid = 0; bus2.wdata = '0; bus2.wstrb = '0; bus2.wvalid = 0; bus2.bready = 0;
        bus4.araddr = '0; bus4.arvalid = 0; bus4.rready = 0;
        bus4.awaddr = '0; bus4.awvalid = 0; bus4.wdata = '0; bus4.wstrb = '0; bus4.wvalid = 0; bus4.bready = 0;

        tick(); tick();
        bus2.arvalid = 1; bus2.awvalid = 1; bus2.wvalid = 1;
        #1;
        chk("rst_arready", bus2.arready, 1'b0);
        chk("rst_awready", bus2.awready, 1'b0);
        chk("rst_rvalid", bus2.rvalid, 1'b0);
        chk("rst_bvalid", bus2.bvalid, 1'b0);
        chk("rst_rdata", bus2.rdata, 64'h0);
        bus2.arvalid = 0; bus2.awvalid = 0; bus2.wvalid = 0;
        tick();
        rst = 1'b0;
        tick();

        rd_req(64'h8000_0004, ok);
        chk("t1_accept", ok, 1'b1);
        #1;
        chk("t1_rvalid_early", bus2.rvalid, 1'b0);
        rd_resp(d, resp, lat);
        chk("t1_latency", lat, 2);
        chk("t1_rdata", d, 64'h00100073_00000413);
        chk("t1_rresp", resp, 2'b00);
        #1;
        chk("t1_rvalid_after", bus2.rvalid, 1'b0);

        wr_req(64'h8000_0010, 64'h1122334455667788, 8'h0F, ok);
        chk("t2_accept", ok, 1'b1);
        wr_resp(resp, lat);
        chk("t2_latency", lat, 2);
        chk("t2_bresp", resp, 2'b00);
        chk("t2_wr_calls", wr_calls, 1);
        rd_req(64'h8000_0010, ok);
        rd_resp(d, resp, lat);
        chk("t2_readback", d, 64'h0000000055667788);

        rd_req(64'h8000_0000, ok);
        tick(); tick();
        chk("t3_rvalid", bus2.rvalid, 1'b1);
        bus2.araddr  = 64'h8000_0010;
        bus2.arvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t3_hold_rvalid", bus2.rvalid, 1'b1);
            chk("t3_hold_rdata", bus2.rdata, 64'h00100073_00000413);
            chk("t3_hold_arready", bus2.arready, 1'b0);
            tick();
        end
        bus2.rready = 1'b1;
        #1;
        chk("t3_hs_arready", bus2.arready, 1'b0);
        tick();
        bus2.rready = 1'b0;
        #1;
        chk("t3_post_rvalid", bus2.rvalid, 1'b0);
        chk("t3_post_arready", bus2.arready, 1'b1);
        tick();
        bus2.arvalid = 1'b0;
        rd_resp(d, resp, lat);
        chk("t3_second_rdata", d, 64'h0000000055667788);

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus2.araddr  = 64'h8000_0000;
            bus2.arvalid = 1'b1;
            bus2.awaddr  = 64'h8000_0020;
            bus2.wdata   = 64'hA5A5_0000_0000_0000 | 64'(i);
            bus2.wstrb   = 8'hFF;
            bus2.awvalid = 1'b1;
            bus2.wvalid  = 1'b1;
            #1;
            got = bus2.arready ? 0 : ((bus2.awready && bus2.wready) ? 1 : 2);
            chk("t4_grant", got, (i % 2 == 0) ? 0 : 1);
            chk("t4_one_group", bus2.arready && bus2.awready, 1'b0);
            tick();
            bus2.arvalid = 0; bus2.awvalid = 0; bus2.wvalid = 0;
            if (got == 0) rd_resp(d, resp, lat);
            else if (got == 1) wr_resp(resp, lat);
        end

        wc = wr_calls;
        bus2.awaddr  = 64'h8000_0030;
        bus2.wdata   = 64'hDEAD_BEEF_0000_0001;
        bus2.wstrb   = 8'hFF;
        bus2.awvalid = 1'b1;
        bus2.wvalid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_lone_awready", bus2.awready, 1'b0);
            chk("t5_lone_wready", bus2.wready, 1'b0);
            tick();
        end
        chk("t5_no_write", wr_calls, wc);
        bus2.wvalid = 1'b1;
        #1;
        chk("t5_awready", bus2.awready, 1'b1);
        chk("t5_wready", bus2.wready, 1'b1);
        tick();
        bus2.awvalid = 0; bus2.wvalid = 0;
        wr_resp(resp, lat);
        chk("t5_latency", lat, 2);
        chk("t5_write_once", wr_calls, wc + 1);
        rd_req(64'h8000_0030, ok);
        rd_resp(d, resp, lat);
        chk("t5_readback", d, 64'hDEAD_BEEF_0000_0001);

        bus4.awaddr = 64'h8000_0008; bus4.wdata = 64'h1; bus4.wstrb = 8'hFF;
        bus4.awvalid = 1; bus4.wvalid = 1;
        #1;
        chk("t6_awready", bus4.awready, 1'b1);
        tick();
        bus4.awvalid = 0; bus4.wvalid = 0;
        tick(); tick(); tick();
        chk("t6_bvalid_l3", bus4.bvalid, 1'b0);
        tick();
        chk("t6_bvalid_l4", bus4.bvalid, 1'b1);
        chk("t6_wr4_once", wr4_calls, 1);
        bus4.bready = 1;
        tick();
        bus4.bready = 0;

        bus4.awvalid = 1; bus4.wvalid = 1;
        tick();
        bus4.awvalid = 0; bus4.wvalid = 0;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_bvalid", bus4.bvalid, 1'b0);
        tick();
        rst = 1'b0;
        bus4.arvalid = 1'b1;
        #1;
        chk("t6_post_bvalid", bus4.bvalid, 1'b0);
        chk("t6_post_arready", bus4.arready, 1'b1);
        bus4.arvalid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_no_commit", wr4_calls, 1);
        chk("t6_idle_bvalid", bus4.bvalid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
